lsu_aligner: RTL and testbench
==============================

# lsu_aligner

Parametrised, handshaked load/store alignment unit between the MIPS core's MEM stage and the data-memory port. It accepts one load/store request at a time, builds the byte-lane strobe and lane-shifted write data, issues a single memory transaction, and returns the sign/zero-extended or merged (LWL/LWR) load result. It sits between the execute/memory pipeline register and the data-memory interface.

## Interface
- DW, 32, data width in bits; legal values 32 or 64; lanes = DW/8
- AW, 32, address width
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  unit can accept a request
- req_op  in  4  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 LWL, 6 LWR, 7 SWL, 8 SWR, 9 SB, 10 SH, 11 SW; 12–15 reserved
- req_addr  in  AW  effective byte address
- req_wdata  in  DW  rt value: store data, and merge source for LWL/LWR
- mem_req_valid  out  1  memory transaction pending
- mem_req_ready  in  1  memory accepts transaction
- mem_wen  out  1  1 = store, 0 = load
- mem_addr  out  AW  req_addr with low log2(lanes) bits cleared
- mem_wstrb  out  DW/8  byte-lane write enables (0 for loads)
- mem_wdata  out  DW  lane-aligned store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DW  full aligned read line
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  DW  load result; 0 for stores
- resp_misalign  out  1  misaligned-access flag, qualified by resp_valid

## Operation
- States: IDLE, MEM, WAIT, RESP. req_ready = (state==IDLE).
- IDLE: on req_valid: capture op, lane offset ea = req_addr[log2(lanes)-1:0], req_wdata; register mem_addr/mem_wen/mem_wstrb/mem_wdata; go MEM. Reserved op: no memory access, go RESP with resp_data=0.
- MEM: mem_req_valid=1, all mem_* stable until mem_req_ready. On handshake: store → RESP; load → WAIT.
- WAIT: mem_rvalid sampled only here; on mem_rvalid compute and register resp_data, go RESP.
- RESP: resp_valid=1, resp_data stable until resp_ready; then IDLE. No new request in the same cycle.
- Word ops select the 32-bit word at lane offset ea[log2(lanes)-1:2] (DW=64: ea[2]); b = ea[1:0].
- LB/LBU: byte at ea, sign-/zero-extended to DW. LH/LHU: halfword at ea[..:1], extension uses that halfword's bit 15. LW: word, sign-extended to DW (DW=64).
- LWL b: {mem[8b+7:0], reg[23-8b:0]} (b=3: whole mem word). LWR b: {reg[31:32-8b], mem[31:8b]} (b=0: whole mem word). Upper DW-32 bits sign-extended from bit 31.
- SB: reg[7:0] to lane ea, one strobe bit. SH: reg[15:0] to halfword, two strobes. SW: word, four strobes.
- SWL b: reg >> 8(3-b), strobes lanes 0..b of the word. SWR b: reg << 8b, strobes lanes b..3.
- Write strobes/data for DW=64 shifted by 4 lanes when ea[2]=1.

## Timing
- Reset: state IDLE; req_ready=1; mem_req_valid, mem_wen, mem_addr, mem_wstrb, mem_wdata, resp_valid, resp_data, resp_misalign all 0.
- Store with mem_req_ready=1: accept cycle 0, mem_req_valid cycle 1, resp_valid cycle 2.
- Load, zero-wait memory (mem_rvalid one cycle after handshake): resp_valid cycle 3.
- Backpressure at any stage holds state and outputs indefinitely.
- rst mid-transaction: immediate return to reset values; pending memory transaction abandoned, no response.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: LW/SW/LWord-sized ops with b≠0, or LH/LHU/SH with ea[0]=1, skip MEM/WAIT: IDLE → RESP, resp_misalign=1, resp_data=0, no memory transaction.
- Undefined: resp_misalign tied 0; misaligned low bits ignored (LW/SW use containing word, halfword ops use ea[..:1]).

## Test plan
- DW=32, SB addr 0x1002, rt=0x000000A5 → mem_wstrb=0100, mem_wdata=0x00A50000, mem_addr=0x1000, resp_valid 2 cycles after accept.
- LH addr 0x2002, mem_rdata=0x8001_7FFF → resp_data=0xFFFF8001; LHU same → 0x00008001.
- LWL addr 0x3001, rt=0x11223344, mem_rdata=0xAABBCCDD → 0xCCDD3344; LWR addr 0x3001 → 0x11AABBCC.
- SWR addr 0x4002, rt=0x11223344 → mem_wstrb=1100, mem_wdata=0x33440000; hold mem_req_ready=0 5 cycles → outputs stable, resp after release.
- DW=64, LB addr 0x5006, mem_rdata=0x0080_0000_0000_0000 → resp_data=0xFFFF_FFFF_FFFF_FF80.
- LSU_MISALIGN_TRAP_EN, LW addr 0x6002 → no mem_req_valid, resp_misalign=1, resp_data=0; rst asserted in WAIT → all outputs reset values next edge.

Source files
------------

// File: rtl/lsu_aligner_if.sv
// lsu_aligner_if: request, data-memory and response bundle for the load/store aligner.
interface lsu_aligner_if #(parameter int DW = 32, parameter int AW = 32);
  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_op;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_wen;
  logic [AW-1:0]   mem_addr;
  logic [DW/8-1:0] mem_wstrb;
  logic [DW-1:0]   mem_wdata;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [DW-1:0]   resp_data;
  logic            resp_misalign;
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_req_ready, mem_rvalid, mem_rdata, resp_ready,
    output req_ready, mem_req_valid, mem_wen, mem_addr, mem_wstrb, mem_wdata, resp_valid, resp_data, resp_misalign
  );
  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_req_ready, mem_rvalid, mem_rdata, resp_ready,
    input  req_ready, mem_req_valid, mem_wen, mem_addr, mem_wstrb, mem_wdata, resp_valid, resp_data, resp_misalign
  );
endinterface

// File: rtl/lsu_aligner.sv
// lsu_aligner: MIPS load/store lane alignment, one memory transaction per request.
// Optional LSU_MISALIGN_TRAP_EN: misaligned LW/SW/halfword ops respond with resp_misalign and skip memory.
module lsu_aligner #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input logic clk,
  input logic rst,
  lsu_aligner_if.slave bus
);
  localparam int NL = DW / 8;
  localparam int LW = $clog2(NL);
  typedef enum logic [1:0] {IDLE, MEM, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] op_q, op_in;
  logic [LW-1:0] ea_q, ea_in;
  logic [31:0] rt_q, rt_in, sd, w, lwl, lwr;
  logic [1:0] b_in, b;
  logic [3:0] ss;
  logic [7:0] bt;
  logic [15:0] hw;
  logic ld_in, rsv_in, mis_in;
  logic [DW-1:0] wdata_in, ld_res;
  logic [NL-1:0] wstrb_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.req_valid ? (rsv_in || mis_in ? RESP : MEM) : IDLE;
      MEM:  state_n = bus.mem_req_ready ? (bus.mem_wen ? RESP : WAIT) : MEM;
      WAIT: state_n = bus.mem_rvalid ? RESP : WAIT;
      RESP: state_n = bus.resp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
    bus.req_ready = state == IDLE;
    bus.mem_req_valid = state == MEM;
    bus.resp_valid = state == RESP;
  end
  // Request side: store data/strobes are built within one 32-bit word, then moved to its word lane.
  always_comb begin
    op_in = bus.req_op;
    ea_in = bus.req_addr[LW-1:0];
    b_in = ea_in[1:0];
    rt_in = bus.req_wdata[31:0];
    rsv_in = op_in > 4'd11;
    ld_in = op_in < 4'd7;
    sd = op_in == 4'd9  ? {24'd0, rt_in[7:0]} << {b_in, 3'd0} :
         op_in == 4'd10 ? {16'd0, rt_in[15:0]} << {b_in[1], 4'd0} :
         op_in == 4'd7  ? rt_in >> {~b_in, 3'd0} :
         op_in == 4'd8  ? rt_in << {b_in, 3'd0} : rt_in;
    ss = op_in == 4'd9  ? 4'b0001 << b_in :
         op_in == 4'd10 ? 4'b0011 << {b_in[1], 1'b0} :
         op_in == 4'd7  ? 4'b1111 >> ~b_in :
         op_in == 4'd8  ? 4'b1111 << b_in : 4'b1111;
    wdata_in = DW'(sd) << {ea_in >> 2, 5'd0};
    wstrb_in = NL'(ss) << {ea_in >> 2, 2'd0};
`ifdef LSU_MISALIGN_TRAP_EN
    mis_in = ((op_in == 4'd0 || op_in == 4'd11) && b_in != 2'd0) ||
             ((op_in == 4'd1 || op_in == 4'd2 || op_in == 4'd10) && b_in[0]);
`else
    mis_in = 1'b0;
`endif
  end
  // Load side: LWL/LWR merge memory bytes over the captured rt value.
  always_comb begin
    b = ea_q[1:0];
    w = 32'(bus.mem_rdata >> {ea_q >> 2, 5'd0});
    bt = 8'(w >> {b, 3'd0});
    hw = 16'(w >> {b[1], 4'd0});
    lwl = (w << {~b, 3'd0}) | (rt_q & ~(32'hFFFF_FFFF << {~b, 3'd0}));
    lwr = (w >> {b, 3'd0}) | (rt_q & ~(32'hFFFF_FFFF >> {b, 3'd0}));
    ld_res = op_q == 4'd1 ? DW'($signed(hw)) :
             op_q == 4'd2 ? DW'(hw) :
             op_q == 4'd3 ? DW'($signed(bt)) :
             op_q == 4'd4 ? DW'(bt) :
             op_q == 4'd5 ? DW'($signed(lwl)) :
             op_q == 4'd6 ? DW'($signed(lwr)) : DW'($signed(w));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q <= '0;
      ea_q <= '0;
      rt_q <= '0;
      bus.mem_wen <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wstrb <= '0;
      bus.mem_wdata <= '0;
      bus.resp_data <= '0;
      bus.resp_misalign <= 1'b0;
    end else if (state == IDLE && bus.req_valid) begin
      op_q <= op_in;
      ea_q <= ea_in;
      rt_q <= rt_in;
      bus.mem_wen <= !(ld_in || rsv_in);
      bus.mem_addr <= {bus.req_addr[AW-1:LW], {LW{1'b0}}};
      bus.mem_wstrb <= ld_in || rsv_in ? '0 : wstrb_in;
      bus.mem_wdata <= ld_in || rsv_in ? '0 : wdata_in;
      bus.resp_data <= '0;
      bus.resp_misalign <= mis_in;
    end else if (state == WAIT && bus.mem_rvalid) bus.resp_data <= ld_res;
endmodule

// File: tb/tb_lsu_aligner.sv
// tb_lsu_aligner: directed checks of lsu_aligner at DW=32 and DW=64.
module tb_lsu_aligner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  lsu_aligner_if #(.DW(32), .AW(32)) b32 ();
  lsu_aligner_if #(.DW(64), .AW(32)) b64 ();
  lsu_aligner #(.DW(32), .AW(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
  lsu_aligner #(.DW(64), .AW(32)) u64 (.clk(clk), .rst(rst), .bus(b64.slave));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue32(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt);
    b32.req_op = op;
    b32.req_addr = addr;
    b32.req_wdata = rt;
    b32.req_valid = 1'b1;
    @(negedge clk);
    b32.req_valid = 1'b0;
  endtask
  task automatic load32(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] rt, input logic [31:0] rdata, input logic [31:0] exp);
    b32.mem_rdata = rdata;
    issue32(op, addr, rt);
    chk({tag, ".mv"}, b32.mem_req_valid, 1);
    chk({tag, ".wen"}, b32.mem_wen, 0);
    @(negedge clk);
    chk({tag, ".early"}, b32.resp_valid, 0);
    @(negedge clk);
    chk({tag, ".rv"}, b32.resp_valid, 1);
    chk({tag, ".data"}, b32.resp_data, exp);
    @(negedge clk);
  endtask
  task automatic store32(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] rt, input logic [3:0] strb, input logic [31:0] data);
    issue32(op, addr, rt);
    chk({tag, ".mv"}, b32.mem_req_valid, 1);
    chk({tag, ".wen"}, b32.mem_wen, 1);
    chk({tag, ".addr"}, b32.mem_addr, {addr[31:2], 2'b00});
    chk({tag, ".strb"}, b32.mem_wstrb, strb);
    chk({tag, ".wdata"}, b32.mem_wdata, data);
    @(negedge clk);
    chk({tag, ".rv"}, b32.resp_valid, 1);
    chk({tag, ".rdata"}, b32.resp_data, 0);
    @(negedge clk);
  endtask
  initial begin
    b32.req_valid = 0; b32.req_op = 0; b32.req_addr = 0; b32.req_wdata = 0;
    b32.mem_req_ready = 1; b32.mem_rvalid = 1; b32.mem_rdata = 0; b32.resp_ready = 1;
    b64.req_valid = 0; b64.req_op = 0; b64.req_addr = 0; b64.req_wdata = 0;
    b64.mem_req_ready = 1; b64.mem_rvalid = 1; b64.mem_rdata = 0; b64.resp_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst.ready", b32.req_ready, 1);
    chk("rst.mv", b32.mem_req_valid, 0);
    chk("rst.wen", b32.mem_wen, 0);
    chk("rst.addr", b32.mem_addr, 0);
    chk("rst.strb", b32.mem_wstrb, 0);
    chk("rst.wdata", b32.mem_wdata, 0);
    chk("rst.rv", b32.resp_valid, 0);
    chk("rst.rdata", b32.resp_data, 0);
    chk("rst.mis", b32.resp_misalign, 0);
    chk("rst64.ready", b64.req_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    store32("sb", 4'd9, 32'h1002, 32'h0000_00A5, 4'b0100, 32'h00A5_0000);
    store32("sh", 4'd10, 32'h4003, 32'h1122_3344, 4'b1100, 32'h3344_0000);
    store32("swl", 4'd7, 32'h4001, 32'h1122_3344, 4'b0011, 32'h0000_1122);
    store32("sw", 4'd11, 32'h4008, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    load32("lh", 4'd1, 32'h2002, 0, 32'h8001_7FFF, 32'hFFFF_8001);
    load32("lhu", 4'd2, 32'h2002, 0, 32'h8001_7FFF, 32'h0000_8001);
    load32("lh0", 4'd1, 32'h2000, 0, 32'h8001_7FFF, 32'h0000_7FFF);
    load32("lb", 4'd3, 32'h1003, 0, 32'h9A00_0000, 32'hFFFF_FF9A);
    load32("lbu", 4'd4, 32'h1003, 0, 32'h9A00_0000, 32'h0000_009A);
    load32("lwl", 4'd5, 32'h3001, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344);
    load32("lwr", 4'd6, 32'h3001, 32'h1122_3344, 32'hAABB_CCDD, 32'h11AA_BBCC);
    load32("lwl3", 4'd5, 32'h3003, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD);
    load32("lwr0", 4'd6, 32'h3000, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD);
    b32.mem_req_ready = 0;
    issue32(4'd8, 32'h4002, 32'h1122_3344);
    for (int i = 0; i < 5; i++) begin
      chk("swr.mv", b32.mem_req_valid, 1);
      chk("swr.strb", b32.mem_wstrb, 4'b1100);
      chk("swr.wdata", b32.mem_wdata, 32'h3344_0000);
      chk("swr.addr", b32.mem_addr, 32'h4000);
      chk("swr.rv", b32.resp_valid, 0);
      @(negedge clk);
    end
    b32.mem_req_ready = 1;
    @(negedge clk);
    chk("swr.resp", b32.resp_valid, 1);
    @(negedge clk);
    b32.resp_ready = 0;
    b32.mem_rdata = 32'h1234_5678;
    issue32(4'd0, 32'h3000, 0);
    repeat (5) @(negedge clk);
    chk("rbp.rv", b32.resp_valid, 1);
    chk("rbp.data", b32.resp_data, 32'h1234_5678);
    chk("rbp.ready", b32.req_ready, 0);
    b32.resp_ready = 1;
    @(negedge clk);
    chk("rbp.idle", b32.req_ready, 1);
    issue32(4'd13, 32'h5000, 32'hFFFF_FFFF);
    chk("rsv.mv", b32.mem_req_valid, 0);
    chk("rsv.rv", b32.resp_valid, 1);
    chk("rsv.data", b32.resp_data, 0);
    @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
    issue32(4'd0, 32'h6002, 0);
    chk("trap.mv", b32.mem_req_valid, 0);
    chk("trap.rv", b32.resp_valid, 1);
    chk("trap.mis", b32.resp_misalign, 1);
    chk("trap.data", b32.resp_data, 0);
    @(negedge clk);
`else
    load32("lwmis", 4'd0, 32'h6002, 0, 32'h8765_4321, 32'h8765_4321);
    chk("lwmis.flag", b32.resp_misalign, 0);
`endif
    b32.mem_rvalid = 0;
    b32.mem_rdata = 32'hDEAD_BEEF;
    issue32(4'd0, 32'h7000, 0);
    chk("rstw.addr", b32.mem_addr, 32'h7000);
    @(negedge clk);
    chk("rstw.wait", b32.mem_req_valid | b32.resp_valid | b32.req_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw.ready", b32.req_ready, 1);
    chk("rstw.maddr", b32.mem_addr, 0);
    chk("rstw.rv", b32.resp_valid, 0);
    chk("rstw.rdata", b32.resp_data, 0);
    rst = 1'b0;
    b32.mem_rvalid = 1;
    repeat (2) @(negedge clk);
    chk("rstw.noresp", b32.resp_valid, 0);
    b64.mem_rdata = 64'h0080_0000_0000_0000;
    b64.req_op = 4'd3; b64.req_addr = 32'h5006; b64.req_valid = 1;
    @(negedge clk);
    b64.req_valid = 0;
    chk("lb64.addr", b64.mem_addr, 32'h5000);
    chk("lb64.strb", b64.mem_wstrb, 0);
    repeat (2) @(negedge clk);
    chk("lb64.rv", b64.resp_valid, 1);
    chk("lb64.data", b64.resp_data, 64'hFFFF_FFFF_FFFF_FF80);
    @(negedge clk);
    b64.req_op = 4'd11; b64.req_addr = 32'h5004; b64.req_wdata = 64'h0000_0000_DEAD_BEEF; b64.req_valid = 1;
    @(negedge clk);
    b64.req_valid = 0;
    chk("sw64.strb", b64.mem_wstrb, 8'hF0);
    chk("sw64.wdata", b64.mem_wdata, 64'hDEAD_BEEF_0000_0000);
    @(negedge clk);
    chk("sw64.rv", b64.resp_valid, 1);
    @(negedge clk);
    b64.mem_rdata = 64'h8000_0000_0000_0001;
    b64.req_op = 4'd0; b64.req_addr = 32'h5004; b64.req_valid = 1;
    @(negedge clk);
    b64.req_valid = 0;
    repeat (2) @(negedge clk);
    chk("lw64.data", b64.resp_data, 64'hFFFF_FFFF_8000_0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
